// File: rtl/uart_tx_queue_if.sv
// uart_send_inf: send handshake between a byte source and the UART transmitter
interface uart_send_inf;
  logic       en;
  logic [7:0] data;
  logic       completed;
  modport sender (output en, output data, input completed);
  modport receiver (input en, input data, output completed);
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding the UART transmitter one byte at a time via en/data/completed
// Define UART_TXQ_STATS_EN to add the tx_count and level_max statistics outputs.
module uart_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef UART_TXQ_STATS_EN
  output logic [15:0]              tx_count,
  output logic [$clog2(DEPTH):0]   level_max,
`endif
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  uart_send_inf.sender             send,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_n, wr_n;
  logic [LW-1:0] level_n;
  logic [7:0]    data_n;
  logic          push, pop;
  assign wr_ready = (level != LW'(DEPTH)) && !flush;
  assign push     = wr_valid && wr_ready;
  assign pop      = (state == ACTIVE) && send.completed;
  assign send.en  = (state == ACTIVE);
  // In ACTIVE the head byte is already on the line, so flush keeps it and drops the rest
  always_comb begin
    state_n = state;
    rd_n    = pop ? AW'(rd + 1'b1) : rd;
    wr_n    = push ? AW'(wr + 1'b1) : wr;
    level_n = level + LW'(push) - LW'(pop);
    data_n  = send.data;
    if (state == IDLE) begin
      if (flush) begin
        wr_n    = rd;
        level_n = '0;
      end else if (level != '0) begin
        data_n  = mem[rd];
        state_n = ACTIVE;
      end
    end else if (flush) begin
      wr_n    = AW'(rd + 1'b1);
      level_n = pop ? LW'(0) : LW'(1);
      state_n = pop ? IDLE : ACTIVE;
    end else if (pop) begin
      data_n  = (level >= LW'(2)) ? mem[AW'(rd + 1'b1)] : send.data;
      state_n = (level >= LW'(2)) ? ACTIVE : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rd          <= '0;
      wr          <= '0;
      level       <= '0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      send.data   <= '0;
    end else begin
      state       <= state_n;
      rd          <= rd_n;
      wr          <= wr_n;
      level       <= level_n;
      empty       <= (level_n == '0);
      almost_full <= (level_n >= LW'(ALMOST_FULL));
      send.data   <= data_n;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= wr_data;
  end
`ifdef UART_TXQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_count  <= '0;
      level_max <= '0;
    end else begin
      tx_count  <= tx_count + 16'(pop);
      level_max <= (level_n > level_max) ? level_n : level_max;
    end
  end
`endif
endmodule
